mem_arbiter: RTL

Two-port to one-port memory arbiter: shares a single unified instruction/data memory between the fetch-stage instruction port (I) and the memory-stage data port (D) of the five-stage RV64I core. Each requester holds a request until it receives a one-cycle ready pulse. The hazard unit stalls the pipeline on `req & ~ready`. D normally has priority. A bounded-wait counter guarantees fetch forward progress.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one unified memory port between the fetch (I) and data (D) requesters.
// D normally wins; a saturating lost-arbitration counter forces an I grant after MAX_WAIT losses.
module mem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          i_win, d_win;

    // Handshake: a requester holds x_req and its command until the single cycle
    // x_ready is high; the memory side holds m_req and the command until m_ack.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        i_win     = 1'b0;
        d_win     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || wait_cnt == CW'(MAX_WAIT))) begin
                    i_win     = 1'b1;
                    state_nxt = GNT_I;
                    wait_nxt  = '0;
                end else if (d_req) begin
                    d_win     = 1'b1;
                    state_nxt = GNT_D;
                    if (!i_req)
                        wait_nxt = '0;
                    else if (wait_cnt != CW'(MAX_WAIT))
                        wait_nxt = wait_cnt + CW'(1);
                end else begin
                    wait_nxt = '0;
                end
            end
            GNT_I:   if (m_ack) state_nxt = IDLE;
            GNT_D:   if (m_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign i_ready = (state == GNT_I) && m_ack;
    assign d_ready = (state == GNT_D) && m_ack;
    assign i_rdata = i_ready ? m_rdata : '0;
    assign d_rdata = d_ready ? m_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            busy     <= (state_nxt != IDLE);
            if (i_win) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
                m_wstrb <= '0;
            end else if (d_win) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_wstrb <= d_we ? d_wstrb : '0;
            end else if (i_ready || d_ready) begin
                // Address and write data are left as-is; only the strobing fields clear.
                m_req   <= 1'b0;
                m_we    <= 1'b0;
                m_wstrb <= '0;
            end
        end
    end

endmodule
